// File: rtl/div_period_checker_if.sv
// Signal bundle between the divider-side driver (master) and div_period_checker (slave).
// high_time and duty_err carry data only when DUTY_CHECK_EN is defined.
interface div_period_checker_if #(
   parameter int WIDTH = 8
);
   logic             q_in;
   logic             enable;
   logic [WIDTH-1:0] div_ratio;
   logic [WIDTH-1:0] period;
   logic             period_valid;
   logic             mismatch;
   logic             locked;
   logic             stuck;
   logic [WIDTH-1:0] high_time;
   logic             duty_err;

   modport master (
      output q_in, enable, div_ratio,
      input  period, period_valid, mismatch, locked, stuck, high_time, duty_err
   );

   modport slave (
      input  q_in, enable, div_ratio,
      output period, period_valid, mismatch, locked, stuck, high_time, duty_err
   );
endinterface

// File: rtl/div_period_checker.sv
// Measures the period of a same-clock divided signal, compares it to div_ratio and tracks lock/stuck.
// Optional duty-cycle check is built when the macro DUTY_CHECK_EN is defined.
module div_period_checker #(
   parameter int WIDTH      = 8,
   parameter int LOCK_COUNT = 4
) (
   input  logic                clk,
   input  logic                rst,
   div_period_checker_if.slave bus
);
   localparam logic [WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [3:0]       LOCK_VAL = 4'(LOCK_COUNT);

   typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE, LOCKED} state_t;

   state_t           state, state_nxt;
   logic             q_s, q_d, rise;
   logic [WIDTH-1:0] cnt, cnt_nxt;
   logic [3:0]       match_cnt, match_nxt;
   logic             complete, saturate;
   logic             ratio_ok, duty_ok, period_ok;
   logic [WIDTH-1:0] period_r;
   logic             period_valid_r, mismatch_r, locked_r, stuck_r;

   assign rise      = q_s & ~q_d;
   assign ratio_ok  = (cnt == bus.div_ratio);
   assign period_ok = ratio_ok & duty_ok;

   // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      match_nxt = match_cnt;
      complete  = 1'b0;
      saturate  = 1'b0;
      if (!bus.enable) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         match_nxt = '0;
      end else begin
         case (state)
            IDLE: state_nxt = WAIT_EDGE;
            WAIT_EDGE: begin
               if (rise) begin
                  state_nxt = MEASURE;
                  cnt_nxt   = WIDTH'(1);
               end
            end
            MEASURE, LOCKED: begin
               if (rise) begin
                  complete = 1'b1;
                  cnt_nxt  = WIDTH'(1);
                  if (period_ok) begin
                     if (match_cnt < LOCK_VAL) match_nxt = match_cnt + 4'd1;
                     state_nxt = (match_nxt == LOCK_VAL) ? LOCKED : MEASURE;
                  end else begin
                     match_nxt = '0;
                     state_nxt = MEASURE;
                  end
               end else if (cnt == CNT_MAX) begin
                  // A rise on the saturating cycle is handled above, so a full-scale period still completes.
                  saturate  = 1'b1;
                  cnt_nxt   = '0;
                  match_nxt = '0;
                  state_nxt = WAIT_EDGE;
               end else begin
                  cnt_nxt = cnt + WIDTH'(1);
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_s            <= 1'b0;
         q_d            <= 1'b0;
         cnt            <= '0;
         match_cnt      <= '0;
         period_r       <= '0;
         period_valid_r <= 1'b0;
         mismatch_r     <= 1'b0;
         locked_r       <= 1'b0;
         stuck_r        <= 1'b0;
      end else begin
         q_s            <= bus.q_in;
         q_d            <= q_s;
         cnt            <= cnt_nxt;
         match_cnt      <= match_nxt;
         period_valid_r <= complete;
         mismatch_r     <= complete & ~ratio_ok;
         locked_r       <= (state_nxt == LOCKED);
         if (complete) period_r <= cnt;
         if (!bus.enable || (state == WAIT_EDGE && rise)) stuck_r <= 1'b0;
         else if (saturate)                                 stuck_r <= 1'b1;
      end
   end

   assign bus.period       = period_r;
   assign bus.period_valid = period_valid_r;
   assign bus.mismatch     = mismatch_r;
   assign bus.locked       = locked_r;
   assign bus.stuck        = stuck_r;

`ifdef DUTY_CHECK_EN
   logic [WIDTH-1:0] high_cnt, high_time_r, half_lo, half_hi;
   logic             duty_err_r;

   assign half_lo = bus.div_ratio >> 1;
   assign half_hi = half_lo + WIDTH'(bus.div_ratio[0]);
   assign duty_ok = (high_cnt == half_lo) || (high_cnt == half_hi);

   // The high counter follows cnt: it clears whenever cnt clears and restarts on the rise cycle (q_s=1).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         high_cnt    <= '0;
         high_time_r <= '0;
         duty_err_r  <= 1'b0;
      end else begin
         duty_err_r <= complete & ~duty_ok;
         if (complete) high_time_r <= high_cnt;
         if (cnt_nxt == '0) high_cnt <= '0;
         else if (rise)     high_cnt <= WIDTH'(1);
         else               high_cnt <= high_cnt + WIDTH'(q_s);
      end
   end

   assign bus.high_time = high_time_r;
   assign bus.duty_err  = duty_err_r;
`else
   assign duty_ok       = 1'b1;
   assign bus.high_time = '0;
   assign bus.duty_err  = 1'b0;
`endif
endmodule

// File: tb/tb_div_period_checker.sv
// Bench for div_period_checker: directed table, corner sequences and random stimulus,
// all checked every cycle against a queue-based period model.
module tb_div_period_checker;
   localparam int WIDTH      = 8;
   localparam int LOCK_COUNT = 4;
   localparam int CMAX       = (1 << WIDTH) - 1;
`ifdef DUTY_CHECK_EN
   localparam bit DUTY = 1'b1;
`else
   localparam bit DUTY = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   div_period_checker_if #(.WIDTH(WIDTH)) bus ();

   div_period_checker #(.WIDTH(WIDTH), .LOCK_COUNT(LOCK_COUNT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a period is the list of q_s samples since the rise that opened it.
   typedef enum {M_OFF, M_ARMED, M_RUN} mphase_t;
   mphase_t     m_phase = M_OFF;
   bit          m_prev1, m_prev2, m_stuck, m_pv, m_mm, m_de;
   bit          m_seg[$];
   int          m_run = 0;
   int unsigned m_period = 0, m_high = 0;

   task automatic model_step(input bit qin, input bit en, input int unsigned dr, input bit rst_now);
      bit          qs, qd, rise, dok;
      int unsigned hi;
      m_pv = 0; m_mm = 0; m_de = 0;
      if (rst_now) begin
         m_phase = M_OFF; m_prev1 = 0; m_prev2 = 0; m_seg.delete();
         m_run = 0; m_stuck = 0; m_period = 0; m_high = 0;
         return;
      end
      qs = m_prev1; qd = m_prev2;
      m_prev2 = m_prev1; m_prev1 = qin;
      rise = qs && !qd;
      if (!en) begin
         m_phase = M_OFF; m_run = 0; m_stuck = 0; m_seg.delete();
      end else begin
         case (m_phase)
            M_OFF: m_phase = M_ARMED;
            M_ARMED: if (rise) begin
               m_phase = M_RUN; m_stuck = 0; m_seg.delete(); m_seg.push_back(qs);
            end
            default: begin
               if (rise) begin
                  hi = 0;
                  foreach (m_seg[i]) hi += m_seg[i];
                  dok = 1;
                  if (DUTY) begin
                     dok = (hi == dr / 2) || (hi == (dr + 1) / 2);
                     m_high = hi;
                     m_de = !dok;
                  end
                  m_pv = 1;
                  m_period = m_seg.size();
                  m_mm = (m_period != dr);
                  if (!m_mm && dok) m_run = (m_run < LOCK_COUNT) ? m_run + 1 : LOCK_COUNT;
                  else              m_run = 0;
                  m_seg.delete(); m_seg.push_back(qs);
               end else if (m_seg.size() == CMAX) begin
                  m_stuck = 1; m_run = 0; m_phase = M_ARMED; m_seg.delete();
               end else begin
                  m_seg.push_back(qs);
               end
            end
         endcase
      end
   endtask

   always @(posedge clk) begin
      model_step(bus.q_in, bus.enable, 32'(bus.div_ratio), rst);
      #1;
      check("cycle",
            32'({bus.period, bus.period_valid, bus.mismatch, bus.locked, bus.stuck, bus.high_time, bus.duty_err}),
            32'({m_period[WIDTH-1:0], m_pv, m_mm, (m_run == LOCK_COUNT), m_stuck, m_high[WIDTH-1:0], m_de}));
   end

   // Stimulus helpers: inputs change on the falling edge; period_valid events are logged there.
   typedef struct {int unsigned period; bit mm; bit locked; int unsigned high; bit de;} ev_t;
   ev_t ev[$];
   int  tk = 0;

   task automatic tick(input bit qv);
      ev_t e;
      @(negedge clk);
      tk++;
      if (bus.period_valid) begin
         e.period = 32'(bus.period); e.mm = bus.mismatch; e.locked = bus.locked;
         e.high = 32'(bus.high_time); e.de = bus.duty_err;
         ev.push_back(e);
      end
      bus.q_in = qv;
   endtask

   task automatic pulse(input int hi, input int lo);
      repeat (hi) tick(1'b1);
      repeat (lo) tick(1'b0);
   endtask

   task automatic restart(input int unsigned ratio);
      tick(1'b0);
      bus.enable = 1'b0;
      tick(1'b0); tick(1'b0);
      bus.div_ratio = WIDTH'(ratio);
      bus.enable = 1'b1;
      repeat (3) tick(1'b0);
      ev.delete();
   endtask

   typedef struct {
      int unsigned ratio, hi, lo, nper, exp_period;
      bit          exp_mm;
      int unsigned lock_at;
      bit          exp_de;
   } vec_t;
   vec_t vecs[5];

   initial begin
      int t0, first, lo, hi;
      bit exp_lock;

      vecs[0] = '{2, 1, 1, 5, 2, 1'b0, 4, 1'b0};
      vecs[1] = '{3, 2, 1, 5, 3, 1'b0, 4, 1'b0};
      vecs[2] = '{4, 1, 3, 5, 4, 1'b0, DUTY ? 0 : 4, DUTY};
      vecs[3] = '{5, 2, 2, 4, 4, 1'b1, 0, 1'b0};
      vecs[4] = '{7, 3, 4, 5, 7, 1'b0, 4, 1'b0};

      bus.q_in = 1'b0; bus.enable = 1'b0; bus.div_ratio = WIDTH'(2);
      repeat (3) @(negedge clk);
      check("reset_outputs",
            32'({bus.period, bus.period_valid, bus.mismatch, bus.locked, bus.stuck, bus.high_time, bus.duty_err}), 0);
      rst = 1'b0;

      for (int v = 0; v < 5; v++) begin
         restart(vecs[v].ratio);
         repeat (vecs[v].nper + 1) pulse(vecs[v].hi, vecs[v].lo);
         tick(1'b0); tick(1'b0);
         check($sformatf("vec%0d_count", v), 32'(ev.size()), vecs[v].nper);
         foreach (ev[i]) begin
            exp_lock = (vecs[v].lock_at != 0) && (i + 1 >= vecs[v].lock_at);
            check($sformatf("vec%0d_period%0d", v, i), ev[i].period, vecs[v].exp_period);
            check($sformatf("vec%0d_mm%0d", v, i), 32'(ev[i].mm), 32'(vecs[v].exp_mm));
            check($sformatf("vec%0d_lock%0d", v, i), 32'(ev[i].locked), 32'(exp_lock));
            check($sformatf("vec%0d_high%0d", v, i), ev[i].high, DUTY ? vecs[v].hi : 0);
            check($sformatf("vec%0d_de%0d", v, i), 32'(ev[i].de), 32'(vecs[v].exp_de));
         end
      end

      // Lock at N=4, stretch one period to 5, relock after four good periods.
      restart(4);
      repeat (6) pulse(2, 2);
      pulse(2, 3);
      repeat (5) pulse(2, 2);
      tick(1'b0); tick(1'b0);
      check("relock_count", 32'(ev.size()), 11);
      if (ev.size() == 11) begin
         check("prelock", 32'(ev[5].locked), 1);
         check("stretch_period", ev[6].period, 5);
         check("stretch_mm", 32'(ev[6].mm), 1);
         check("stretch_unlock", 32'(ev[6].locked), 0);
         check("relock_3rd", 32'(ev[9].locked), 0);
         check("relock_4th", 32'(ev[10].locked), 1);
      end

      // q_in stops while locked: stuck 257 ticks after the last driven rise.
      restart(4);
      repeat (6) pulse(2, 2);
      tick(1'b1); t0 = tk; tick(1'b1);
      first = 0;
      for (int i = 0; i < 300; i++) begin
         tick(1'b0);
         if (i == 2) check("pre_stuck_lock", 32'(bus.locked), 1);
         if (bus.stuck && first == 0) first = tk;
      end
      check("stuck_latency", 32'(first - t0), 257);
      check("stuck_level", 32'(bus.stuck), 1);
      check("stuck_unlock", 32'(bus.locked), 0);
      ev.delete();
      pulse(2, 2); tick(1'b0); tick(1'b0);
      check("stuck_cleared", 32'(bus.stuck), 0);
      check("resume_no_pv", 32'(ev.size()), 0);

      // Rise exactly on the saturating count completes a full-scale period.
      restart(254);
      tick(1'b1);
      repeat (254) tick(1'b0);
      tick(1'b1);
      repeat (3) tick(1'b0);
      check("full_count", 32'(ev.size()), 1);
      if (ev.size() == 1) begin
         check("full_period", ev[0].period, CMAX);
         check("full_mm", 32'(ev[0].mm), 1);
      end
      check("full_no_stuck", 32'(bus.stuck), 0);

      // Asynchronous reset in the middle of a measurement.
      restart(4);
      repeat (3) pulse(2, 2);
      tick(1'b1);
      rst = 1'b1;
      #1;
      check("rst_async",
            32'({bus.period, bus.period_valid, bus.mismatch, bus.locked, bus.stuck, bus.high_time, bus.duty_err}), 0);
      tick(1'b1);
      rst = 1'b0;
      ev.delete();
      tick(1'b1); tick(1'b0); tick(1'b0);
      check("rst_first_rise", 32'(ev.size()), 0);

      // enable dropped while locked: lock clears, period holds.
      restart(4);
      repeat (6) pulse(2, 2);
      check("lock_before_disable", 32'(bus.locked), 1);
      bus.enable = 1'b0;
      ev.delete();
      tick(1'b1); tick(1'b1); tick(1'b0);
      check("disable_unlock", 32'(bus.locked), 0);
      check("disable_hold_period", 32'(bus.period), 4);
      check("disable_no_stuck", 32'(bus.stuck), 0);
      repeat (2) pulse(2, 2);
      bus.enable = 1'b1;
      tick(1'b0); tick(1'b0);
      pulse(2, 2); tick(1'b0); tick(1'b0);
      check("reenable_first_rise", 32'(ev.size()), 0);

      // Random traffic, including ratio changes, enable drops and reset pulses.
      restart(4);
      for (int r = 0; r < 350; r++) begin
         int unsigned sel;
         sel = $urandom_range(0, 99);
         if (sel < 4) begin
            bus.enable = 1'b0;
            tick(1'($urandom_range(0, 1)));
            bus.enable = 1'b1;
         end else if (sel < 6) begin
            rst = 1'b1;
            tick(1'($urandom_range(0, 1)));
            rst = 1'b0;
         end else if (sel < 18) begin
            bus.div_ratio = WIDTH'($urandom_range(2, 6));
         end
         if ($urandom_range(0, 2) != 0) begin
            lo = int'(bus.div_ratio) / 2;
            hi = int'(bus.div_ratio) - lo;
         end else begin
            hi = $urandom_range(1, 4);
            lo = $urandom_range(1, 4);
         end
         pulse(hi, lo);
      end
      tick(1'b0); tick(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
